instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the PC, presents a word address to the combinational instruction memory, and captures the returned instruction into a small prefetch queue.
- Hands {instruction, pc} to the decode stage over a valid/ready handshake.
- Handles pipeline redirects (branch resolution, flush); sits between instruction memory and the IF/ID boundary.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch queue entries; legal range 1..8.
- CNT_W, 4, width of queue_count; must hold DEPTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals pc_q; word-aligned.
- imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  flush queue and load new PC.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- fd_valid  out  1  queue head holds a valid entry.
- fd_ready  in  1  decode accepts head this cycle.
- fd_instr  out  32  instruction at queue head.
- fd_pc  out  32  PC of fd_instr.
- fd_pred_taken  out  1  head was fetched under a predicted-taken branch (feature only).
- queue_count  out  CNT_W  number of valid queue entries.

Behaviour:
- Reset (sync, reset=1 at clk edge): pc_q=RESET_PC, count=0, rd/wr pointers=0. Outputs: fd_valid=0, fd_instr=0, fd_pc=0, fd_pred_taken=0, queue_count=0, imem_addr=RESET_PC.
- Reset mid-operation: same as above; all queued entries discarded; redirect ignored that cycle.
- imem_addr = pc_q combinationally. Memory read is zero-latency; imem_data is sampled at the same edge that advances pc_q.
- pop = fd_valid & fd_ready. push = ~redirect_valid & (count<DEPTH | pop).
- On push:
  - entry {imem_data, pc_q, pred} is written at the wr pointer.
  - pc_q <= next_pc, where next_pc = pc_q+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) unless a prediction is made (feature).
- Full and no pop: no push; pc_q holds; imem_addr stable.
- Full with pop in the same cycle: push and pop both occur; count unchanged.
- Empty: fd_valid=0; fd_instr/fd_pc hold last driven values (don't-care for the bench); pop is impossible.
- Head outputs are driven from queue storage, never combinationally from imem_data. First fd_valid=1 appears 1 cycle after reset deasserts.
- Redirect (highest priority, beats push and pop):
  - count<=0 and pointers reset; pc_q <= {redirect_pc[31:2],2'b00}.
  - The entry fetched that cycle is discarded.
  - fd_valid=0 in the next cycle; the first redirected entry is visible 2 cycles after redirect_valid is sampled.
  - A pop presented in the redirect cycle is not counted as accepted.
- Back-to-back redirects: the last one wins; the queue stays empty until a cycle without redirect.
- queue_count = count (registered).
- Throughput: 1 instruction/cycle sustained when fd_ready=1 continuously.
- No instruction decode except the optional predictor; all-zero words (nop) are passed through like any other word.

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN.
- Defined: pre-decodes imem_data on push.
  - Condition: opcode imem_data[31:26]==6'b000100 (beq) and imm[15]==1 (backward).
  - Action: next_pc = pc_q+4+(sext(imm)<<2), and the entry's pred=1 (visible as fd_pred_taken).
  - Forward and non-branch instructions use pc_q+4 with pred=0.
  - Mispredict recovery is owned by execute via redirect.
- Not defined: no pre-decode; next_pc always pc_q+4; fd_pred_taken tied to 0.

Test Plan:
- Reset, then fd_ready=1 constantly, memory words W0..W3 at 0x0,0x4,0x8,0xC -> fd_valid rises 1 cycle after reset; fd_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles with matching fd_instr; queue_count stays at 1.
- fd_ready=0 for 5 cycles from reset (DEPTH=2) -> queue_count goes 1,2,2,2,2; imem_addr holds 0x8; then fd_ready=1 -> outputs 0x0,0x4,0x8 in order, no loss or duplication.
- Queue full (count=2), redirect_valid=1 with redirect_pc=0x43 -> next cycle fd_valid=0, queue_count=0, imem_addr=0x40; following cycle fd_pc=0x40.
- pc_q=0xFFFF_FFFC with fd_ready=1 -> next imem_addr=0x0000_0000; entries show fd_pc 0xFFFF_FFFC then 0x0.
- reset asserted for 1 cycle with count=2 and redirect_valid=1 -> queue_count=0, imem_addr=RESET_PC, fd_valid=0; redirect ignored.
- With FETCH_STATIC_PREDICT_EN: beq imm=16'hFFF7 at 0x2C -> next imem_addr=0x0C, entry fd_pred_taken=1. Without the macro: next imem_addr=0x30, fd_pred_taken=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a zero-latency instruction memory and buffers
// {instr, pc, pred} in a small queue toward decode. Optional macro: FETCH_STATIC_PREDICT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             fd_valid,
    input  logic             fd_ready,
    output logic [31:0]      fd_instr,
    output logic [31:0]      fd_pc,
    output logic             fd_pred_taken,
    output logic [CNT_W-1:0] queue_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_epc   [DEPTH];
    logic             r_pred  [DEPTH];

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_seq_pc;
    logic [31:0]      w_next_pc;
    logic             w_pred;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign imem_addr     = r_pc;
    assign fd_valid      = (r_count != '0);
    assign fd_instr      = r_instr[r_rd_ptr];
    assign fd_pc         = r_epc[r_rd_ptr];
    assign fd_pred_taken = r_pred[r_rd_ptr];
    assign queue_count   = r_count;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_pop    = fd_valid & fd_ready;
    assign w_push   = ~redirect_valid & (~w_full | w_pop);
    assign w_seq_pc = r_pc + 32'd4;

`ifdef FETCH_STATIC_PREDICT_EN
    // Backward beq is assumed taken; execute redirects on a mispredict.
    always_comb begin
        w_pred    = (imem_data[31:26] == 6'b000100) & imem_data[15];
        w_next_pc = w_seq_pc;
        if (w_pred)
            w_next_pc = w_seq_pc + {{14{imem_data[15]}}, imem_data[15:0], 2'b00};
    end
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = w_seq_pc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_epc[i]   <= '0;
                r_pred[i]  <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Flush wins over push and pop; the word fetched this cycle is dropped.
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= imem_data;
                r_epc[r_wr_ptr]   <= r_pc;
                r_pred[r_wr_ptr]  <= w_pred;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
                r_pc              <= w_next_pc;
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
